uart_debug_master: RTL and testbench
====================================

# uart_debug_master

Host-side initiator for the 500 kbps UART debug protocol used to load and inspect the asm18 core. Takes one command at a time from a local requester, serialises the 5-byte header and any 3-byte-per-word write payload, and reassembles 3-byte-per-word read responses into 18-bit words. Sits between a test/loader sequencer and byte-level uart_tx/uart_rx cores, on the far end of the serial link from the on-chip debug controller.

## Interface
- WORD_SIZE, 18, payload word width; protocol fixes it at 18.
- RX_TIMEOUT_CLKS, 5000000, maximum clocks allowed between read-response bytes.
- GAP_CLKS, 64, idle clocks inserted after every command before cmd_ready returns.

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd  in  4  command code 0..9
- cmd_address  in  16  header address field
- cmd_size  in  16  header size field (words, or step count, or LED value)
- wr_word  in  WORD_SIZE  write payload word
- wr_valid / wr_ready  in / out  1 / 1  write-word handshake
- rd_word  out  WORD_SIZE  assembled read word
- rd_valid  out  1  one-cycle strobe, no backpressure
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at normal completion
- timeout_err  out  1  one-cycle pulse at read timeout
- tx_byte  out  8  byte to uart_tx
- tx_send  out  1  one-cycle send strobe
- tx_done  in  1  uart_tx byte-finished strobe
- rx_byte  in  8  byte from uart_rx
- rx_valid  in  1  uart_rx byte strobe

## Operation
- Reset: state IDLE; cmd_ready=1, all other outputs 0; counters cleared. Reset mid-command abandons it silently (no done/timeout_err).
- States: IDLE -> HDR -> {WR, RD, GAP} -> GAP -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready latch cmd, address, size; go HDR.
- HDR: send 5 bytes in order {4'b0,cmd}, addr[7:0], addr[15:8], size[7:0], size[15:8]. Then: size==0 -> GAP; cmd 1 or 3 -> WR; cmd 2, 4 or 8 -> RD; otherwise -> GAP.
- WR: per word, wr_ready=1 while waiting; capture on wr_valid&wr_ready, then send word[7:0], word[15:8], {6'b0,word[17:16]}. Word counter decrements after third byte; at 0 -> GAP.
- RD: rx bytes fill [7:0], [15:8], [17:16] (bits 7:2 of third byte ignored). After third byte pulse rd_valid with word; counter decrements; at 0 -> GAP.
- rx_valid outside RD ignored. tx_done outside a pending send ignored.
- GAP: count GAP_CLKS clocks, pulse done, return IDLE (covers responder-side processing of CLEAR/STEP/SET_LED).
- Word counter 16-bit; cmd_size=16'hFFFF is legal (65535 words), no wrap.

## Timing
- tx_send asserted the cycle after entry to HDR and the cycle after word capture in WR; each following byte's tx_send no earlier than the cycle after tx_done. Exactly one tx_send per tx_done.
- wr_ready combinational from state; word captured in the handshake cycle, first byte's tx_send next cycle.
- rd_valid asserts the cycle after the third byte's rx_valid.
- done asserts in the last GAP cycle; cmd_ready rises the following cycle.
- Minimum command latency, size==0: 5 byte times + GAP_CLKS + 2 clocks.

## Configuration
- UART_MASTER_RX_TIMEOUT_EN defined: timeout counter reloads to RX_TIMEOUT_CLKS on entry to RD and on each rx_valid; reaching 0 pulses timeout_err, discards the partial word and remaining count, and goes to GAP; done is not pulsed for that command.
- Undefined: no counter; RD waits indefinitely; timeout_err tied 0.

## Test plan
- Reset held mid-HDR, then released -> cmd_ready=1, busy=0, no tx_send until the next command.
- cmd=0, address=0, size=16'h00A5 -> bytes 00,00,00,A5,00 on tx_byte; no wr_ready; done after gap.
- cmd=1, address=16'h0102, size=2, words 18'h3ABCD, 18'h00001 -> bytes 01,02,01,02,00,CD,AB,03,01,00,00; two wr_ready handshakes.
- cmd=2, size=1, model returns bytes 34,12,FE -> rd_word=18'h21234, one rd_valid, done.
- With UART_MASTER_RX_TIMEOUT_EN and RX_TIMEOUT_CLKS=100: cmd=4, size=2, only 4 response bytes -> one rd_valid, timeout_err 100 clocks after the 4th byte, no done.
- wr_valid held low 1000 clocks in WR -> no tx_send during the stall; sequence resumes correctly once wr_valid rises.

Source files
------------

// File: rtl/uart_debug_master_if.sv
// Requester-side bundle of uart_debug_master: command, write-word and read-word
// handshakes plus status strobes. The master modport is the sequencer side.
interface uart_debug_master_if #(
  parameter int WORD_SIZE = 18
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd;
  logic [15:0]          cmd_address;
  logic [15:0]          cmd_size;
  logic [WORD_SIZE-1:0] wr_word;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 rd_valid;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;

  modport master (
    output cmd_valid, cmd, cmd_address, cmd_size, wr_word, wr_valid,
    input  cmd_ready, wr_ready, rd_word, rd_valid, busy, done, timeout_err
  );

  modport slave (
    input  cmd_valid, cmd, cmd_address, cmd_size, wr_word, wr_valid,
    output cmd_ready, wr_ready, rd_word, rd_valid, busy, done, timeout_err
  );
endinterface

// File: rtl/uart_debug_master.sv
// Host-side initiator of the UART debug protocol: sends 5-byte headers and write
// payloads, reassembles read words. Read timeout enabled by UART_MASTER_RX_TIMEOUT_EN.
module uart_debug_master #(
  parameter int WORD_SIZE       = 18,
  parameter int RX_TIMEOUT_CLKS = 5000000,
  parameter int GAP_CLKS        = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  uart_debug_master_if.slave req,
  output logic [7:0]         tx_byte,
  output logic               tx_send,
  input  logic               tx_done,
  input  logic [7:0]         rx_byte,
  input  logic               rx_valid
);
  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLKS - 1);

  typedef enum logic [2:0] {IDLE, HDR, WR, RD, GAP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [15:0]          addr_q, addr_d;
  logic [15:0]          count_q, count_d;
  logic [2:0]           idx_q, idx_d;
  logic [WORD_SIZE-1:0] word_q, word_d;
  logic                 have_q, have_d;
  logic                 pending_q, pending_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 tx_send_q, tx_send_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [WORD_SIZE-1:0] rd_word_q, rd_word_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 abort_q, abort_d;
  logic                 done_q, done_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 busy_q, busy_d;
`ifdef UART_MASTER_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(RX_TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(RX_TIMEOUT_CLKS);
  logic [TO_W-1:0] to_q, to_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    count_d     = count_q;
    idx_d       = idx_q;
    word_d      = word_q;
    have_d      = have_q;
    pending_d   = pending_q;
    tx_byte_d   = tx_byte_q;
    tx_send_d   = 1'b0;
    gap_d       = gap_q;
    rd_word_d   = rd_word_q;
    rd_valid_d  = 1'b0;
    abort_d     = abort_q;
`ifdef UART_MASTER_RX_TIMEOUT_EN
    to_d        = to_q;
    timeout_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req.cmd_valid && cmd_ready_q) begin
          cmd_d     = req.cmd;
          addr_d    = req.cmd_address;
          count_d   = req.cmd_size;
          tx_byte_d = {4'b0, req.cmd};
          tx_send_d = 1'b1;
          pending_d = 1'b1;
          idx_d     = 3'd1;
          abort_d   = 1'b0;
          state_d   = HDR;
        end
      end
      HDR: begin
        if (pending_q && tx_done) begin
          if (idx_q == 3'd5) begin
            pending_d = 1'b0;
            idx_d     = 3'd0;
            have_d    = 1'b0;
            if (count_q == 16'd0) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end else if (cmd_q == 4'd1 || cmd_q == 4'd3) begin
              state_d = WR;
            end else if (cmd_q == 4'd2 || cmd_q == 4'd4 || cmd_q == 4'd8) begin
              state_d = RD;
`ifdef UART_MASTER_RX_TIMEOUT_EN
              to_d    = TO_LOAD;
`endif
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            tx_send_d = 1'b1;
            idx_d     = idx_q + 3'd1;
            unique case (idx_q)
              3'd1:    tx_byte_d = addr_q[7:0];
              3'd2:    tx_byte_d = addr_q[15:8];
              3'd3:    tx_byte_d = count_q[7:0];
              default: tx_byte_d = count_q[15:8];
            endcase
          end
        end
      end
      // have_q separates "waiting for a word" from "shifting its three bytes out".
      WR: begin
        if (!have_q) begin
          if (req.wr_valid) begin
            word_d    = req.wr_word;
            have_d    = 1'b1;
            tx_byte_d = req.wr_word[7:0];
            tx_send_d = 1'b1;
            pending_d = 1'b1;
            idx_d     = 3'd1;
          end
        end else if (pending_q && tx_done) begin
          if (idx_q == 3'd3) begin
            pending_d = 1'b0;
            have_d    = 1'b0;
            idx_d     = 3'd0;
            count_d   = count_q - 16'd1;
            if (count_q == 16'd1) begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            tx_send_d = 1'b1;
            idx_d     = idx_q + 3'd1;
            tx_byte_d = (idx_q == 3'd1) ? word_q[15:8] : {6'b0, word_q[17:16]};
          end
        end
      end
      RD: begin
        if (rx_valid) begin
`ifdef UART_MASTER_RX_TIMEOUT_EN
          to_d = TO_LOAD;
`endif
          unique case (idx_q)
            3'd0: begin
              word_d[7:0] = rx_byte;
              idx_d       = 3'd1;
            end
            3'd1: begin
              word_d[15:8] = rx_byte;
              idx_d        = 3'd2;
            end
            default: begin
              rd_word_d  = {rx_byte[1:0], word_q[15:0]};
              rd_valid_d = 1'b1;
              idx_d      = 3'd0;
              count_d    = count_q - 16'd1;
              if (count_q == 16'd1) begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
              end
            end
          endcase
        end
`ifdef UART_MASTER_RX_TIMEOUT_EN
        else if (to_q == TO_W'(1)) begin
          to_d      = '0;
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          idx_d     = 3'd0;
          count_d   = 16'd0;
          state_d   = GAP;
          gap_d     = GAP_LOAD;
        end else begin
          to_d = to_q - TO_W'(1);
        end
`endif
      end
      GAP: begin
        if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
        else             state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // done is registered one cycle early so it lands on the last GAP cycle.
    done_d      = (state_d == GAP) && (gap_d == '0) && !abort_d;
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      addr_q      <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      word_q      <= '0;
      have_q      <= 1'b0;
      pending_q   <= 1'b0;
      tx_byte_q   <= '0;
      tx_send_q   <= 1'b0;
      gap_q       <= '0;
      rd_word_q   <= '0;
      rd_valid_q  <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef UART_MASTER_RX_TIMEOUT_EN
      to_q        <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      have_q      <= have_d;
      pending_q   <= pending_d;
      tx_byte_q   <= tx_byte_d;
      tx_send_q   <= tx_send_d;
      gap_q       <= gap_d;
      rd_word_q   <= rd_word_d;
      rd_valid_q  <= rd_valid_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
`ifdef UART_MASTER_RX_TIMEOUT_EN
      to_q        <= to_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign tx_byte         = tx_byte_q;
  assign tx_send         = tx_send_q;
  assign req.cmd_ready   = cmd_ready_q;
  assign req.wr_ready    = (state_q == WR) && !have_q;
  assign req.rd_word     = rd_word_q;
  assign req.rd_valid    = rd_valid_q;
  assign req.busy        = busy_q;
  assign req.done        = done_q;
`ifdef UART_MASTER_RX_TIMEOUT_EN
  assign req.timeout_err = timeout_q;
`else
  // Timeout hardware absent; the comparison is constant-false for any legal value.
  assign req.timeout_err = (RX_TIMEOUT_CLKS < 0);
`endif
endmodule

// File: tb/tb_uart_debug_master.sv
// Self-checking bench for uart_debug_master: directed commands, a uart_tx byte
// model with a scoreboard of expected header/payload bytes and read words.
module tb_uart_debug_master;
  localparam int WORD_SIZE = 18;
  localparam int GAP       = 64;
  localparam int TX_LAT    = 3;
`ifdef UART_MASTER_RX_TIMEOUT_EN
  localparam int RX_TO     = 100;
`else
  localparam int RX_TO     = 5000000;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_byte;
  logic       tx_send;
  logic       tx_done;
  logic [7:0] rx_byte;
  logic       rx_valid;

  always #5 clock = ~clock;

  uart_debug_master_if #(.WORD_SIZE(WORD_SIZE)) req ();

  uart_debug_master #(
    .WORD_SIZE(WORD_SIZE),
    .RX_TIMEOUT_CLKS(RX_TO),
    .GAP_CLKS(GAP)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .req(req.slave),
    .tx_byte(tx_byte),
    .tx_send(tx_send),
    .tx_done(tx_done),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid)
  );

  int         nAsserts = 0;
  int         nFails = 0;
  int         doneCount = 0;
  int         timeoutCount = 0;
  int         txCount = 0;
  int         wrReadyCycles = 0;
  logic       txBusy = 1'b0;
  logic [7:0] txQ[$];
  logic [17:0] rdQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // uart_tx model: one tx_done per tx_send after TX_LAT cycles; checks each byte.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clock);
      while (tx_send) begin
        txBusy = 1'b1;
        txCount++;
        nAsserts++;
        assert (txQ.size() != 0) else begin
          nFails++;
          $error("[TB] FAIL tx_unexpected observed=%0h expected=none", tx_byte);
        end
        if (txQ.size() != 0) checkOutput("tx_byte", tx_byte, txQ.pop_front());
        for (int i = 0; i < TX_LAT; i++) begin
          @(negedge clock);
          checkOutput("tx_send_while_busy", tx_send, 0);
        end
        tx_done = 1'b1;
        @(negedge clock);
        tx_done = 1'b0;
      end
      txBusy = 1'b0;
    end
  end

  always @(negedge clock) begin
    if (req.done) doneCount++;
    if (req.timeout_err) timeoutCount++;
    if (req.wr_ready) wrReadyCycles++;
    if (req.rd_valid) begin
      nAsserts++;
      assert (rdQ.size() != 0) else begin
        nFails++;
        $error("[TB] FAIL rd_unexpected observed=%0h expected=none", req.rd_word);
      end
      if (rdQ.size() != 0) checkOutput("rd_word", req.rd_word, rdQ.pop_front());
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] c, input logic [15:0] a, input logic [15:0] s);
    int cyc = 0;
    @(negedge clock);
    while (!req.cmd_ready && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("cmd_ready_idle", req.cmd_ready, 1);
    txQ.push_back({4'h0, c});
    txQ.push_back(a[7:0]);
    txQ.push_back(a[15:8]);
    txQ.push_back(s[7:0]);
    txQ.push_back(s[15:8]);
    req.cmd = c;
    req.cmd_address = a;
    req.cmd_size = s;
    req.cmd_valid = 1'b1;
    @(posedge clock);
    #1;
    req.cmd_valid = 1'b0;
    checkOutput("busy_after_accept", req.busy, 1);
  endtask

  task automatic sendWord(input logic [17:0] w);
    int cyc = 0;
    @(negedge clock);
    while (!req.wr_ready && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("wr_ready_wait", req.wr_ready, 1);
    txQ.push_back(w[7:0]);
    txQ.push_back(w[15:8]);
    txQ.push_back({6'b0, w[17:16]});
    req.wr_word = w;
    req.wr_valid = 1'b1;
    @(posedge clock);
    #1;
    req.wr_valid = 1'b0;
    checkOutput("wr_ready_drop", req.wr_ready, 0);
  endtask

  task automatic waitTxIdle();
    int cyc = 0;
    while ((txQ.size() != 0 || txBusy) && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("tx_drained", txQ.size(), 0);
  endtask

  task automatic sendRx(input logic [7:0] b);
    @(negedge clock);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic rxWord(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [17:0] exp);
    rdQ.push_back(exp);
    sendRx(b0);
    sendRx(b1);
    sendRx(b2);
    checkOutput("rd_valid_timing", req.rd_valid, 1);
  endtask

  task automatic waitDone(input string tag);
    int cyc = 0;
    while (!req.done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput({tag, "_done"}, req.done, 1);
    checkOutput({tag, "_ready_low_at_done"}, req.cmd_ready, 0);
    @(negedge clock);
    checkOutput({tag, "_done_one_cycle"}, req.done, 0);
    checkOutput({tag, "_ready_after_done"}, req.cmd_ready, 1);
    checkOutput({tag, "_idle_not_busy"}, req.busy, 0);
    checkOutput({tag, "_tx_left"}, txQ.size(), 0);
    checkOutput({tag, "_rd_left"}, rdQ.size(), 0);
  endtask

  initial begin
    int wr0;
    int d0;
    int t0;
    int base;
    int cyc;
    logic sawSend;
    req.cmd_valid = 1'b0;
    req.cmd = '0;
    req.cmd_address = '0;
    req.cmd_size = '0;
    req.wr_word = '0;
    req.wr_valid = 1'b0;
    rx_byte = '0;
    rx_valid = 1'b0;

    repeat (3) @(negedge clock);
    checkOutput("rst_cmd_ready", req.cmd_ready, 1);
    checkOutput("rst_busy", req.busy, 0);
    checkOutput("rst_tx_send", tx_send, 0);
    checkOutput("rst_wr_ready", req.wr_ready, 0);
    checkOutput("rst_rd_valid", req.rd_valid, 0);
    checkOutput("rst_done", req.done, 0);
    checkOutput("rst_timeout", req.timeout_err, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Plain command: header only, no write handshakes.
    wr0 = wrReadyCycles;
    applyStimulus(4'd0, 16'h0000, 16'h00A5);
    waitDone("cmd0");
    checkOutput("cmd0_no_wr_ready", wrReadyCycles - wr0, 0);

    // Two-word write with a long stall before the second word.
    applyStimulus(4'd1, 16'h0102, 16'd2);
    sendWord(18'h3ABCD);
    repeat (1000) @(negedge clock);
    checkOutput("stall_wr_ready_held", req.wr_ready, 1);
    sendWord(18'h00001);
    waitDone("cmd1");

    // Single-word read; upper bits of third byte ignored.
    wr0 = wrReadyCycles;
    applyStimulus(4'd2, 16'h0040, 16'd1);
    waitTxIdle();
    rxWord(8'h34, 8'h12, 8'hFE, 18'h21234);
    waitDone("cmd2");
    checkOutput("cmd2_no_wr_ready", wrReadyCycles - wr0, 0);

    // Stray rx byte while idle must not produce a word.
    sendRx(8'h55);
    checkOutput("rx_idle_ignored", req.rd_valid, 0);
    checkOutput("rx_idle_busy", req.busy, 0);

    // Read command with size 0 and a non-transfer command go straight to the gap.
    applyStimulus(4'd8, 16'h0000, 16'd0);
    waitDone("cmd8_size0");
    applyStimulus(4'd9, 16'hFFFF, 16'd3);
    waitDone("cmd9");

`ifdef UART_MASTER_RX_TIMEOUT_EN
    applyStimulus(4'd4, 16'h0000, 16'd2);
    waitTxIdle();
    d0 = doneCount;
    t0 = timeoutCount;
    rxWord(8'h11, 8'h22, 8'h01, 18'h12211);
    sendRx(8'h33);
    cyc = 0;
    while (!req.timeout_err && cyc < 300) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("timeout_seen", req.timeout_err, 1);
    checkOutput("timeout_delay", cyc, 100);
    repeat (80) @(negedge clock);
    checkOutput("timeout_no_done", doneCount - d0, 0);
    checkOutput("timeout_one_pulse", timeoutCount - t0, 1);
    checkOutput("timeout_back_idle", req.cmd_ready, 1);
    checkOutput("timeout_rd_left", rdQ.size(), 0);
`else
    // Read stays pending indefinitely without the timeout feature.
    applyStimulus(4'd4, 16'h1234, 16'd2);
    waitTxIdle();
    rxWord(8'hCD, 8'hAB, 8'hFF, 18'h3ABCD);
    repeat (300) @(negedge clock);
    checkOutput("rd_wait_busy", req.busy, 1);
    checkOutput("rd_wait_not_ready", req.cmd_ready, 0);
    rxWord(8'h00, 8'h00, 8'h00, 18'h00000);
    waitDone("cmd4");
    checkOutput("no_timeout", timeoutCount, 0);
`endif

    // Reset in the middle of a header abandons the command silently.
    base = txCount;
    applyStimulus(4'd5, 16'hBEEF, 16'd7);
    cyc = 0;
    while (txCount < base + 2 && cyc < 500) begin
      @(negedge clock);
      cyc++;
    end
    checkOutput("hdr_progress", txCount >= base + 2, 1);
    reset_n = 1'b0;
    d0 = doneCount;
    repeat (20) @(negedge clock);
    txQ.delete();
    checkOutput("midrst_ready", req.cmd_ready, 1);
    checkOutput("midrst_busy", req.busy, 0);
    reset_n = 1'b1;
    sawSend = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (tx_send) sawSend = 1'b1;
    end
    checkOutput("midrst_no_tx", sawSend, 0);
    checkOutput("midrst_no_done", doneCount - d0, 0);
    checkOutput("midrst_ready_after", req.cmd_ready, 1);

    applyStimulus(4'd0, 16'h0000, 16'd0);
    waitDone("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
